// File: rtl/gelu_stream_unit_if.sv
// Stream and coefficient-programming bundle for gelu_stream_unit.
// master drives beats and cfg writes; slave is the compute unit.
interface gelu_stream_unit_if #(
    parameter int W         = 64,
    parameter int NUM_LANES = 32,
    parameter int SEG_BITS  = 3,
    parameter int CW        = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_LANES*W-1:0]    in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_LANES*W-1:0]    out_data;
    logic                      cfg_we;
    logic [SEG_BITS-1:0]       cfg_addr;
    logic [CW-1:0]             cfg_k;
    logic [CW-1:0]             cfg_b;

    modport master (
        output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_k, cfg_b,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_k, cfg_b,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/gelu_stream_unit.sv
// Piecewise-linear GELU over NUM_LANES lanes, 3-cycle latency, 1 beat/cycle; stages stall only when full and
// blocked, so in_ready follows out_ready combinationally. GELU_STREAM_STATS_EN adds beat/saturation counters.
module gelu_stream_unit #(
    parameter int W         = 64,
    parameter int Q         = 16,
    parameter int NUM_LANES = 32,
    parameter int SEG_BITS  = 3,
    parameter int CW        = 32,
    parameter int CQ        = 22
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef GELU_STREAM_STATS_EN
    output logic [31:0]        stat_beats,
    output logic [31:0]        stat_sat,
`endif
    gelu_stream_unit_if.slave  bus
);
    localparam int NUM_SEG   = 1 << SEG_BITS;
    localparam int PW        = W + CW;
    localparam int SW        = PW + 1;
    localparam int SEG_SHIFT = Q + 3 - SEG_BITS;

    localparam logic signed [W-1:0] C_POS4 = W'(1) << (Q + 2);
    localparam logic signed [W-1:0] C_NEG4 = -C_POS4;
    localparam logic signed [W-1:0] C_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] C_MIN  = {1'b1, {(W-1){1'b0}}};

    // ---------------- coefficient table ----------------
    logic signed [CW-1:0] r_k [NUM_SEG];
    logic signed [CW-1:0] r_b [NUM_SEG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SEG; s++) begin
                r_k[s] <= '0;
                r_b[s] <= '0;
            end
        end else if (bus.cfg_we) begin
            r_k[bus.cfg_addr] <= bus.cfg_k;
            r_b[bus.cfg_addr] <= bus.cfg_b;
        end
    end

    // ---------------- pipeline control ----------------
    logic r_s1_vld, r_s2_vld, r_s3_vld;
    logic w_adv1, w_adv2, w_adv3;

    assign w_adv3        = !r_s3_vld || bus.out_ready;
    assign w_adv2        = !r_s2_vld || w_adv3;
    assign w_adv1        = !r_s1_vld || w_adv2;
    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = r_s3_vld;

    // ---------------- S1: capture, classify, table snapshot ----------------
    logic signed [W-1:0]  w_x   [NUM_LANES];
    logic [SEG_BITS-1:0]  w_seg [NUM_LANES];

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            w_x[i]   = $signed(bus.in_data[i*W +: W]);
            w_seg[i] = SEG_BITS'((w_x[i] + C_POS4) >> SEG_SHIFT);
        end
    end

    logic signed [W-1:0]  r_s1_x [NUM_LANES];
    logic signed [CW-1:0] r_s1_k [NUM_LANES];
    logic signed [CW-1:0] r_s1_b [NUM_LANES];
    logic [NUM_LANES-1:0] r_s1_lo, r_s1_hi;

    // Table reads see pre-write contents, so a same-cycle cfg write only affects later beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_lo  <= '0;
            r_s1_hi  <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_s1_x[i] <= '0;
                r_s1_k[i] <= '0;
                r_s1_b[i] <= '0;
            end
        end else if (w_adv1) begin
            r_s1_vld <= bus.in_valid;
            if (bus.in_valid) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    r_s1_x[i]  <= w_x[i];
                    r_s1_lo[i] <= (w_x[i] < C_NEG4);
                    r_s1_hi[i] <= (w_x[i] >= C_POS4);
                    r_s1_k[i]  <= r_k[w_seg[i]];
                    r_s1_b[i]  <= r_b[w_seg[i]];
                end
            end
        end
    end

    // ---------------- S2: full-width product ----------------
    logic signed [PW-1:0] w_prod [NUM_LANES];

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            w_prod[i] = $signed({{CW{r_s1_x[i][W-1]}}, r_s1_x[i]}) *
                        $signed({{W{r_s1_k[i][CW-1]}}, r_s1_k[i]});
        end
    end

    logic signed [PW-1:0] r_s2_prod [NUM_LANES];
    logic signed [W-1:0]  r_s2_x    [NUM_LANES];
    logic signed [CW-1:0] r_s2_b    [NUM_LANES];
    logic [NUM_LANES-1:0] r_s2_lo, r_s2_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_s2_lo  <= '0;
            r_s2_hi  <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_s2_prod[i] <= '0;
                r_s2_x[i]    <= '0;
                r_s2_b[i]    <= '0;
            end
        end else if (w_adv2) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_lo <= r_s1_lo;
                r_s2_hi <= r_s1_hi;
                for (int i = 0; i < NUM_LANES; i++) begin
                    r_s2_prod[i] <= w_prod[i];
                    r_s2_x[i]    <= r_s1_x[i];
                    r_s2_b[i]    <= r_s1_b[i];
                end
            end
        end
    end

    // ---------------- S3: align, add, saturate, select region ----------------
    logic signed [PW-1:0] w_pq  [NUM_LANES];
    logic signed [CW-1:0] w_bq  [NUM_LANES];
    logic [SW-1:0]        w_sum [NUM_LANES];
    logic [NUM_LANES-1:0] w_ovf;
    logic signed [W-1:0]  w_y   [NUM_LANES];

    // Overflow when the bits above the W-bit result disagree with its sign.
    always_comb begin
        w_ovf = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_pq[i]  = r_s2_prod[i] >>> CQ;
            w_bq[i]  = r_s2_b[i] >>> (CQ - Q);
            w_sum[i] = {w_pq[i][PW-1], w_pq[i]} + {{(SW-CW){w_bq[i][CW-1]}}, w_bq[i]};
            w_ovf[i] = (w_sum[i][SW-1:W-1] != {(SW-W+1){w_sum[i][SW-1]}});
            if (r_s2_lo[i])
                w_y[i] = '0;
            else if (r_s2_hi[i])
                w_y[i] = r_s2_x[i];
            else if (w_ovf[i])
                w_y[i] = w_sum[i][SW-1] ? C_MIN : C_MAX;
            else
                w_y[i] = $signed(w_sum[i][W-1:0]);
        end
    end

    logic signed [W-1:0]  r_s3_y [NUM_LANES];
`ifdef GELU_STREAM_STATS_EN
    logic [NUM_LANES-1:0] r_s3_sat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_vld <= 1'b0;
`ifdef GELU_STREAM_STATS_EN
            r_s3_sat <= '0;
`endif
            for (int i = 0; i < NUM_LANES; i++)
                r_s3_y[i] <= '0;
        end else if (w_adv3) begin
            r_s3_vld <= r_s2_vld;
            if (r_s2_vld) begin
`ifdef GELU_STREAM_STATS_EN
                r_s3_sat <= w_ovf & ~r_s2_lo & ~r_s2_hi;
`endif
                for (int i = 0; i < NUM_LANES; i++)
                    r_s3_y[i] <= w_y[i];
            end
        end
    end

    logic [NUM_LANES*W-1:0] w_out;

    always_comb begin
        w_out = '0;
        for (int i = 0; i < NUM_LANES; i++)
            w_out[i*W +: W] = r_s3_y[i];
    end

    assign bus.out_data = w_out;

`ifdef GELU_STREAM_STATS_EN
    localparam int CNT_W = $clog2(NUM_LANES + 1);

    logic [CNT_W-1:0] w_sat_cnt;
    logic [31:0]      r_stat_beats;
    logic [31:0]      r_stat_sat;

    always_comb begin
        w_sat_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++)
            w_sat_cnt = w_sat_cnt + CNT_W'(r_s3_sat[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_beats <= '0;
            r_stat_sat   <= '0;
        end else if (r_s3_vld && bus.out_ready) begin
            r_stat_beats <= r_stat_beats + 32'd1;
            r_stat_sat   <= r_stat_sat + 32'(w_sat_cnt);
        end
    end

    assign stat_beats = r_stat_beats;
    assign stat_sat   = r_stat_sat;
`endif
endmodule

// File: doc/gelu_stream_unit.md
Name: gelu_stream_unit

Overview:
- Pipelined successor to the combinational GELU compute unit.
- NUM_LANES lanes of piecewise-linear GELU run in parallel behind a valid/ready stream interface.
- Coefficients live in a runtime-programmable register table, so the unit needs no fixed shared LUT.
- Sits between the FFN matmul output buffer and the next-layer input buffer; one beat carries all lanes.

Parameters:
- W, 64, data width per lane (signed, Q(W-Q).Q).
- Q, 16, data fractional bits.
- NUM_LANES, 32, parallel lanes per beat.
- SEG_BITS, 3, log2 of segment count (NUM_SEG = 2^SEG_BITS), segments uniform over [-4.0, 4.0).
- CW, 32, coefficient width (signed).
- CQ, 22, coefficient fractional bits (CQ >= Q).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_data  in  NUM_LANES*W  lane i at [i*W +: W].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_LANES*W  lane i result.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  SEG_BITS  segment index.
- cfg_k  in  CW  slope, Q(CW-CQ).CQ.
- cfg_b  in  CW  intercept, Q(CW-CQ).CQ.

Behaviour:
- Per lane:
  - x < -4.0 → y = 0.
  - x >= 4.0 → y = x.
  - Otherwise: seg = (x + 4.0) >> (Q+3-SEG_BITS) (unsigned). y = sat_W(((k[seg]*x) >>> CQ) + (sext(b[seg]) >>> (CQ-Q))).
- Multiply is full width W+CW signed, and shifts are arithmetic.
- sat_W clamps to the signed W-bit min/max.
- Pipeline has 3 stages, each holding one valid bit plus lane data:
  - S1: register x, region flags, segment index. Also snapshot k and b per lane.
  - S2: product.
  - S3: add, saturate, output register.
- A stage advances when it is empty or its successor advances. Bubbles collapse.
- in_ready = !S1.valid || S1 advances (combinational from out_ready through the chain).
- Latency with out_ready held high is 3 cycles from the accept edge to out_valid. Throughput is 1 beat per cycle.
- Stream handshake rules:
  - out_valid/out_data stay stable while out_valid && !out_ready.
  - No beat is dropped or duplicated.
  - Full occupancy is 3 beats.
- Coefficient timing:
  - A beat uses the table contents at the cycle it is accepted.
  - A cfg write in the same cycle as an accept is NOT visible to that beat; it is visible to beats accepted from the next cycle on.
  - In-flight beats are unaffected by later writes.
- cfg writes are accepted every cycle, independent of stream state. Repeated writes to the same address: the last one wins.
- Reset (async assert, sync-safe release):
  - All stage valids = 0, so out_valid = 0 and in_ready = 1 after reset.
  - out_data = 0.
  - All k and b = 0. With the default table, the mid region outputs 0.
- Reset mid-operation discards in-flight beats immediately.
- in_valid with all-lane data: lanes are independent, and lanes in different regions in the same beat are legal.

Optional Feature:
- Macro GELU_STREAM_STATS_EN.
- When defined:
  - Adds outputs stat_beats (32 bits) and stat_sat (32 bits).
  - stat_beats increments on each out_valid && out_ready.
  - stat_sat increments by the number of lanes clamped by sat_W in the beat leaving S3 (accepted beats only).
  - Both counters wrap at 2^32 and reset to 0.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Default table, lanes = {5.0 (0x50000), -4.5, 0.5} → outputs {0x50000, 0, 0}, exactly 3 cycles after accept.
- Write k[4]=0x200000 (0.5), b[4]=0x100000 (0.25); x=0.5 (0x8000) → y=0x8000. x=-0.5 (seg 3, table zero) → y=0.
- Stream 8 consecutive beats with out_ready=1 → 8 outputs on consecutive cycles, in order, in_ready never deasserted.
- Hold out_ready=0 for 6 cycles while offering 5 beats:
  - in_ready drops after the 3rd beat is accepted.
  - out_data is held stable.
  - On release, all 5 beats emerge in order with none lost.
- Accept a beat with x=0.5 in the same cycle as a write of k[4]=0x400000 → that beat yields 0x8000 (old table). The next beat yields 0xC000.
- Assert rst_n low with 3 beats in flight → out_valid=0 at once, in_ready=1 after release, and x=0.5 then yields 0 (table cleared). With GELU_STREAM_STATS_EN: both counters read 0.
